// File: rtl/rs_issue_scheduler.sv
// Age-ordered reservation station: captures operands off the CDB, issues the
// oldest ready op to a single ALU and compacts the queue on removal.
module rs_issue_scheduler #(
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int A_WIDTH = 3,
  parameter int ENTRIES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dispatchValid,
  output logic                  dispatchReady,
  input  logic [A_WIDTH:0]      dispatchControl,
  input  logic [ROB:0]          dispatchRob,
  input  logic [WIDTH:0]        src1Val,
  input  logic [WIDTH:0]        src2Val,
  input  logic [ROB:0]          src1Tag,
  input  logic [ROB:0]          src2Tag,
  input  logic                  src1Ready,
  input  logic                  src2Ready,
  input  logic                  cdbValid,
  input  logic [ROB:0]          cdbRob,
  input  logic [WIDTH:0]        cdbResult,
  input  logic                  aluAvailable,
  output logic                  issueValid,
  output logic [WIDTH:0]        src1,
  output logic [WIDTH:0]        src2,
  output logic [A_WIDTH:0]      ALUControl,
  output logic [ROB:0]          ALURob,
  output logic [$clog2(ENTRIES):0] occupancy
);
  localparam int LW = $clog2(ENTRIES);

  typedef struct packed {
    logic             vld;
    logic [A_WIDTH:0] ctl;
    logic [ROB:0]     rob;
    logic             r1;
    logic [ROB:0]     t1;
    logic [WIDTH:0]   v1;
    logic             r2;
    logic [ROB:0]     t2;
    logic [WIDTH:0]   v2;
  } ent_t;

  ent_t ent  [ENTRIES];
  ent_t woke [ENTRIES];
  ent_t nxt  [ENTRIES];
  ent_t din;

  logic [LW:0]         cnt;
  logic [LW:0]         wr;
  logic [ENTRIES-1:0]  elig;
  logic [LW-1:0]       sel;
  logic                iss, acc;

  assign occupancy     = cnt;
  assign dispatchReady = (cnt < (LW+1)'(ENTRIES));
  assign acc           = dispatchValid & dispatchReady;
  assign iss           = aluAvailable & (|elig);

  // Eligibility looks only at registered state, so a same-edge wakeup waits a cycle.
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int i = 0; i < ENTRIES; i++)
      elig[i] = ent[i].vld & ent[i].r1 & ent[i].r2;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (elig[i]) sel = LW'(i);
  end

  always_comb begin
    din     = '0;
    din.vld = 1'b1;
    din.ctl = dispatchControl;
    din.rob = dispatchRob;
    din.t1  = src1Tag;
    din.t2  = src2Tag;
    din.r1  = src1Ready;
    din.v1  = src1Val;
    din.r2  = src2Ready;
    din.v2  = src2Val;
    if (!src1Ready && cdbValid && cdbRob == src1Tag) begin
      din.r1 = 1'b1;
      din.v1 = cdbResult;
    end
    if (!src2Ready && cdbValid && cdbRob == src2Tag) begin
      din.r2 = 1'b1;
      din.v2 = cdbResult;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      woke[i] = ent[i];
      if (cdbValid && ent[i].vld && !ent[i].r1 && ent[i].t1 == cdbRob) begin
        woke[i].r1 = 1'b1;
        woke[i].v1 = cdbResult;
      end
      if (cdbValid && ent[i].vld && !ent[i].r2 && ent[i].t2 == cdbRob) begin
        woke[i].r2 = 1'b1;
        woke[i].v2 = cdbResult;
      end
    end
  end

  // Compact above the issued slot, then append the new op at the (post-issue) tail.
  always_comb begin
    wr = cnt - (LW+1)'(iss);
    for (int i = 0; i < ENTRIES; i++)
      nxt[i] = woke[i];
    for (int i = 0; i < ENTRIES-1; i++)
      if (iss && i >= int'(sel)) nxt[i] = woke[i+1];
    if (iss) nxt[ENTRIES-1] = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (acc && wr == (LW+1)'(i)) nxt[i] = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      cnt        <= '0;
      issueValid <= 1'b0;
      src1       <= '0;
      src2       <= '0;
      ALUControl <= '0;
      ALURob     <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      cnt        <= '0;
      issueValid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= nxt[i];
      cnt        <= cnt + (LW+1)'(acc) - (LW+1)'(iss);
      issueValid <= iss;
      if (iss) begin
        src1       <= ent[sel].v1;
        src2       <= ent[sel].v2;
        ALUControl <= ent[sel].ctl;
        ALURob     <= ent[sel].rob;
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench: a queue-based reference model predicts issues and occupancy;
// a negedge monitor compares them against the scheduler outputs.
module tb_rs_issue_scheduler;
  localparam int WIDTH = 31, ROB = 2, A_WIDTH = 3, ENTRIES = 4;
  localparam int LW = $clog2(ENTRIES);

  logic clk = 0, reset = 1, flush = 0;
  logic dispatchValid = 0, dispatchReady;
  logic [A_WIDTH:0] dispatchControl = '0;
  logic [ROB:0] dispatchRob = '0, src1Tag = '0, src2Tag = '0, cdbRob = '0, ALURob;
  logic [WIDTH:0] src1Val = '0, src2Val = '0, cdbResult = '0, src1, src2;
  logic src1Ready = 0, src2Ready = 0, cdbValid = 0, aluAvailable = 0, issueValid;
  logic [A_WIDTH:0] ALUControl;
  logic [LW:0] occupancy;

  rs_issue_scheduler #(.WIDTH(WIDTH), .ROB(ROB), .A_WIDTH(A_WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatchValid(dispatchValid), .dispatchReady(dispatchReady),
    .dispatchControl(dispatchControl), .dispatchRob(dispatchRob),
    .src1Val(src1Val), .src2Val(src2Val), .src1Tag(src1Tag), .src2Tag(src2Tag),
    .src1Ready(src1Ready), .src2Ready(src2Ready),
    .cdbValid(cdbValid), .cdbRob(cdbRob), .cdbResult(cdbResult),
    .aluAvailable(aluAvailable), .issueValid(issueValid),
    .src1(src1), .src2(src2), .ALUControl(ALUControl), .ALURob(ALURob),
    .occupancy(occupancy));

  always #5 clk = ~clk;

  typedef struct {
    logic [A_WIDTH:0] ctl; logic [ROB:0] rob;
    bit r1; logic [ROB:0] t1; logic [WIDTH:0] v1;
    bit r2; logic [ROB:0] t2; logic [WIDTH:0] v2;
  } op_t;
  typedef struct { logic [WIDTH:0] v1, v2; logic [A_WIDTH:0] ctl; logic [ROB:0] rob; } iss_t;

  op_t  q[$];
  iss_t expq[$];
  bit   exp_iv;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per rising edge, using the inputs held at that edge.
  always @(posedge clk) begin
    int oldsz, hit;
    op_t n;
    if (reset || flush) begin
      q.delete();
      exp_iv = 0;
    end else begin
      oldsz = q.size();
      hit = -1;
      if (aluAvailable)
        foreach (q[i]) if (hit < 0 && q[i].r1 && q[i].r2) hit = i;
      if (cdbValid)
        foreach (q[i]) begin
          if (!q[i].r1 && q[i].t1 == cdbRob) begin q[i].r1 = 1; q[i].v1 = cdbResult; end
          if (!q[i].r2 && q[i].t2 == cdbRob) begin q[i].r2 = 1; q[i].v2 = cdbResult; end
        end
      exp_iv = (hit >= 0);
      if (hit >= 0) begin
        expq.push_back('{q[hit].v1, q[hit].v2, q[hit].ctl, q[hit].rob});
        q.delete(hit);
      end
      if (dispatchValid && oldsz < ENTRIES) begin
        n = '{dispatchControl, dispatchRob, src1Ready, src1Tag, src1Val,
              src2Ready, src2Tag, src2Val};
        if (!n.r1 && cdbValid && cdbRob == n.t1) begin n.r1 = 1; n.v1 = cdbResult; end
        if (!n.r2 && cdbValid && cdbRob == n.t2) begin n.r2 = 1; n.v2 = cdbResult; end
        q.push_back(n);
      end
    end
  end

  always @(negedge clk) begin
    iss_t e;
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("dispatchReady", 64'(dispatchReady), 64'(q.size() < ENTRIES));
    chk("issueValid", 64'(issueValid), 64'(exp_iv));
    if (issueValid) begin
      if (expq.size() == 0) chk("unexpected_issue", 64'(1), 64'(0));
      else begin
        e = expq.pop_front();
        chk("src1", 64'(src1), 64'(e.v1));
        chk("src2", 64'(src2), 64'(e.v2));
        chk("ALUControl", 64'(ALUControl), 64'(e.ctl));
        chk("ALURob", 64'(ALURob), 64'(e.rob));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    dispatchValid = 0; cdbValid = 0; flush = 0;
  endtask

  task automatic disp(input logic [A_WIDTH:0] c, input logic [ROB:0] r,
                      input bit r1, input logic [ROB:0] t1, input logic [WIDTH:0] v1,
                      input bit r2, input logic [ROB:0] t2, input logic [WIDTH:0] v2);
    dispatchValid = 1; dispatchControl = c; dispatchRob = r;
    src1Ready = r1; src1Tag = t1; src1Val = v1;
    src2Ready = r2; src2Tag = t2; src2Val = v2;
  endtask

  task automatic cdb(input logic [ROB:0] r, input logic [WIDTH:0] v);
    cdbValid = 1; cdbRob = r; cdbResult = v;
  endtask

  initial begin
    tick(3);
    chk("rst_src1", 64'(src1), 64'(0));
    chk("rst_src2", 64'(src2), 64'(0));
    chk("rst_ctl", 64'(ALUControl), 64'(0));
    chk("rst_rob", 64'(ALURob), 64'(0));
    reset = 0;
    tick();
    chk("ready_after_reset", 64'(dispatchReady), 64'(1));

    // basic ready op
    aluAvailable = 1;
    disp(4'h0, 3, 1, 0, 5, 1, 0, 7); tick();
    tick();
    chk("basic_src1", 64'(src1), 64'(5));
    tick(2);
    // wait on tag 2, then broadcast
    disp(4'h2, 1, 0, 2, 0, 1, 0, 9); tick(3);
    cdb(2, 32'hDEAD); tick(4);
    // fill to capacity; fifth is dropped
    aluAvailable = 0;
    for (int i = 0; i < 5; i++) begin disp(4'(i), 3'(i), 1, 0, 32'(100+i), 1, 0, 32'(i)); tick(); end
    chk("full_ready", 64'(dispatchReady), 64'(0));
    chk("full_occ", 64'(occupancy), 64'(4));
    aluAvailable = 1; tick(6);
    // oldest waits, younger ones bypass it
    aluAvailable = 0;
    disp(4'h1, 0, 0, 5, 0, 1, 0, 11); tick();
    disp(4'h2, 1, 1, 0, 21, 1, 0, 22); tick();
    disp(4'h3, 2, 1, 0, 31, 1, 0, 32); tick();
    aluAvailable = 1; tick(3);
    chk("wait_occ", 64'(occupancy), 64'(1));
    cdb(5, 32'h55); tick(4);
    // same-cycle capture at dispatch
    disp(4'h4, 6, 1, 0, 3, 0, 4, 0); cdb(4, 32'h1234); tick(3);
    // flush overrides dispatch and issue
    aluAvailable = 0;
    disp(4'h5, 7, 1, 0, 1, 1, 0, 2); tick();
    aluAvailable = 1; flush = 1;
    disp(4'h6, 5, 1, 0, 3, 1, 0, 4); tick();
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_iv", 64'(issueValid), 64'(0));
    tick(2);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(9) < 7)
        disp(4'($urandom), 3'($urandom), $urandom_range(9) < 6, 3'($urandom), $urandom,
             $urandom_range(9) < 6, 3'($urandom), $urandom);
      if ($urandom_range(9) < 4) cdb(3'($urandom), $urandom);
      aluAvailable = $urandom_range(9) < 7;
      flush = $urandom_range(99) < 2;
      tick();
    end
    aluAvailable = 0; tick(2);
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 31, data MSB index.
REQ-002 SHALL have parameter ROB, default 2, ROB tag MSB index.
REQ-003 SHALL have parameter A_WIDTH, default 3, ALU control MSB index.
REQ-004 SHALL have parameter ENTRIES, default 4, station depth, a power of two and at least 2.
REQ-005 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1 bit, mispredict squash of all entries.
REQ-008 SHALL have port dispatchValid, input, 1 bit, new op offered.
REQ-009 SHALL have port dispatchReady, output, 1 bit, station can accept.
REQ-010 SHALL have port dispatchControl, input, A_WIDTH+1 bits, ALU operation.
REQ-011 SHALL have port dispatchRob, input, ROB+1 bits, destination ROB tag.
REQ-012 SHALL have ports src1Val and src2Val, input, WIDTH+1 bits each, operand values.
REQ-013 SHALL have ports src1Tag and src2Tag, input, ROB+1 bits each, producer tags.
REQ-014 SHALL have ports src1Ready and src2Ready, input, 1 bit each, value valid; when low, the matching Tag applies.
REQ-015 SHALL have ports cdbValid (1 bit), cdbRob (ROB+1 bits) and cdbResult (WIDTH+1 bits), inputs, common data bus broadcast.
REQ-016 SHALL have port aluAvailable, input, 1 bit, ALU can accept an op this cycle.
REQ-017 SHALL have port issueValid, output, 1 bit, registered one-cycle issue pulse.
REQ-018 SHALL have ports src1 and src2 (WIDTH+1 bits), ALUControl (A_WIDTH+1 bits) and ALURob (ROB+1 bits), outputs, registered issued op.
REQ-019 SHALL have port occupancy, output, log2(ENTRIES)+1 bits, count of valid entries.

Function
REQ-020 SHALL hold entries in age order, slot 0 oldest; each entry holds valid, control, rob, and per operand ready, tag, value.
REQ-021 SHALL drive dispatchReady = (occupancy < ENTRIES), derived from registered state only; it SHALL be low when full even if an issue occurs that cycle.
REQ-022 SHALL accept a dispatch on a rising edge where dispatchValid && dispatchReady, writing slot [occupancy after this edge's issue removal].
REQ-023 SHALL, for each dispatched operand with ready low, cdbValid high and cdbRob == tag in the same cycle, capture cdbResult and mark the operand ready.
REQ-024 SHALL, each edge with cdbValid high, set ready and load cdbResult in every valid entry operand whose ready is low and tag == cdbRob.
REQ-025 SHALL treat an entry as eligible when valid and both operands ready in registered state; same-edge CDB wakeup gives eligibility on the following edge.
REQ-026 SHALL, on an edge with aluAvailable high and at least one eligible entry, select the lowest-index eligible entry, load it into src1/src2/ALUControl/ALURob, set issueValid, and remove it.
REQ-027 SHALL compact on removal: entries above the issued slot shift down one position in the same edge, preserving their CDB updates from that edge.
REQ-028 SHALL clear issueValid on any edge without an issue; issue outputs SHALL hold their last values when issueValid is low.
REQ-029 SHALL update occupancy as occupancy + dispatch - issue per edge, never exceeding ENTRIES or going below 0.
REQ-030 SHALL give minimum dispatch-to-issue latency of one cycle: dispatch at edge N with both operands ready gives issueValid high after edge N+1.
REQ-031 SHALL never issue an entry in the same edge it is dispatched.
REQ-032 SHALL, on flush high, invalidate all entries, set occupancy 0 and clear issueValid at that edge; flush SHALL override dispatch, wakeup and issue in that cycle.

Reset
REQ-033 SHALL, on an edge with reset high, clear all entry valid bits, occupancy, issueValid, src1, src2, ALUControl and ALURob to 0; reset SHALL take priority over flush and all other inputs.
REQ-034 SHALL drive dispatchReady high in the first cycle after reset deasserts.

Verification
REQ-035 SHALL cover: dispatch op 4'h0, ROB 3, src1 5, src2 7, both ready, aluAvailable=1 -> issueValid pulses the next cycle with src1=5, src2=7, ALURob=3, then occupancy 0.
REQ-036 SHALL cover: dispatch with src1 waiting on tag 2, then cdbValid with cdbRob=2 and cdbResult=32'hDEAD -> issue one cycle after the broadcast with src1=32'hDEAD.
REQ-037 SHALL cover: fill 4 entries with aluAvailable=0 -> dispatchReady=0, occupancy=4; a fifth dispatchValid is ignored.
REQ-038 SHALL cover: entries 0 (waiting) and 1, 2 (ready), aluAvailable=1 -> entry 1 issues first, then entry 2, and entry 0 compacts to slot 0.
REQ-039 SHALL cover: dispatch with tag matching same-cycle CDB broadcast -> value captured and issue next cycle.
REQ-040 SHALL cover: flush together with dispatch and an eligible entry -> no issue, occupancy 0, dispatchReady=1 the next cycle.
